bomb_keypad_decoder: RTL and testbench

Input side of the bomb-defuse game. It scans a 4x4 matrix keypad, debounces and decodes key presses, and collects a 4-digit defuse code. It compares the entry against a secret code and drives the `success` level consumed by the countdown/display block. It also drives `boom` on timer expiry or too many wrong attempts.

---
 rtl/bomb_keypad_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_bomb_keypad_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_keypad_decoder.sv
// Keypad scanner, debouncer and defuse-code FSM for the bomb game.
// Optional WRONG_PENALTY_EN adds a `penalty` pulse on each non-fatal wrong '#'.
module bomb_keypad_decoder #(
    parameter int          SCAN_DIV  = 1000,
    parameter int          DEBOUNCE  = 4,
    parameter logic [15:0] CODE      = 16'h2580,
    parameter int          MAX_TRIES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        armed,
    input  logic        expired,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic [2:0]  tries,
    output logic        success,
    output logic        boom
`ifdef WRONG_PENALTY_EN
    ,
    output logic        penalty
`endif
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ENTRY     = 2'd1;
    localparam logic [1:0] DEFUSED   = 2'd2;
    localparam logic [1:0] DETONATED = 2'd3;

    logic [SW-1:0] slot;
    logic [1:0]    ridx;
    logic [3:0]    col_s1, col_s2;
    logic          sample, pass_end;

    logic          hit;
    logic [1:0]    hit_col;
    logic [3:0]    hit_code;
    logic [1:0]    acc_rows;
    logic [3:0]    acc_code;
    logic          p_valid;
    logic [3:0]    p_code;

    logic [3:0]    cand;
    logic [DW-1:0] cand_cnt, none_cnt, nxt_cnt;
    logic          held;

    logic [1:0]    state;

    assign sample   = (slot == SW'(SCAN_DIV - 1));
    assign pass_end = sample && (ridx == 2'd3);
    assign row      = ~(4'b0001 << ridx);
    assign success  = (state == DEFUSED);
    assign boom     = (state == DETONATED);

    always_comb begin
        hit     = 1'b1;
        hit_col = 2'd0;
        case (col_s2)
            4'b1110: hit_col = 2'd0;
            4'b1101: hit_col = 2'd1;
            4'b1011: hit_col = 2'd2;
            4'b0111: hit_col = 2'd3;
            default: hit = 1'b0;
        endcase
        case ({ridx, hit_col})
            4'h0: hit_code = 4'd1;   4'h1: hit_code = 4'd2;
            4'h2: hit_code = 4'd3;   4'h3: hit_code = 4'd10;
            4'h4: hit_code = 4'd4;   4'h5: hit_code = 4'd5;
            4'h6: hit_code = 4'd6;   4'h7: hit_code = 4'd11;
            4'h8: hit_code = 4'd7;   4'h9: hit_code = 4'd8;
            4'hA: hit_code = 4'd9;   4'hB: hit_code = 4'd12;
            4'hC: hit_code = 4'd14;  4'hD: hit_code = 4'd0;
            4'hE: hit_code = 4'd15;  default: hit_code = 4'd13;
        endcase
        // Pass is valid only if exactly one row in the whole pass produced a hit
        p_valid = (acc_rows == 2'd0 && hit) || (acc_rows == 2'd1 && !hit);
        p_code  = hit ? hit_code : acc_code;
        nxt_cnt = (cand_cnt != '0 && p_code == cand) ? cand_cnt + DW'(1) : DW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1   <= '1;
            col_s2   <= '1;
            slot     <= '0;
            ridx     <= '0;
            acc_rows <= '0;
            acc_code <= '0;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
            if (sample) begin
                slot <= '0;
                ridx <= ridx + 2'd1;
                if (pass_end) begin
                    acc_rows <= '0;
                end else if (hit) begin
                    if (acc_rows == 2'd0) acc_code <= hit_code;
                    if (acc_rows != 2'd2) acc_rows <= acc_rows + 2'd1;
                end
            end else begin
                slot <= slot + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            cand      <= '0;
            cand_cnt  <= '0;
            none_cnt  <= '0;
            held      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (pass_end) begin
                if (held) begin
                    // A registered key must be seen absent before another press counts
                    if (p_valid) begin
                        none_cnt <= '0;
                    end else if (none_cnt == DW'(DEBOUNCE - 1)) begin
                        held     <= 1'b0;
                        none_cnt <= '0;
                    end else begin
                        none_cnt <= none_cnt + DW'(1);
                    end
                end else if (p_valid) begin
                    if (nxt_cnt == DW'(DEBOUNCE)) begin
                        key_valid <= 1'b1;
                        key_code  <= p_code;
                        held      <= 1'b1;
                        cand_cnt  <= '0;
                    end else begin
                        cand     <= p_code;
                        cand_cnt <= nxt_cnt;
                    end
                end else begin
                    cand_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            entry     <= '0;
            entry_cnt <= '0;
            tries     <= '0;
`ifdef WRONG_PENALTY_EN
            penalty   <= 1'b0;
`endif
        end else begin
`ifdef WRONG_PENALTY_EN
            penalty <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    entry     <= '0;
                    entry_cnt <= '0;
                    if (armed) state <= ENTRY;
                end
                ENTRY: begin
                    if (expired) begin
                        state <= DETONATED;
                    end else if (!armed) begin
                        state     <= IDLE;
                        entry     <= '0;
                        entry_cnt <= '0;
                    end else if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (entry_cnt < 3'd4) begin
                                entry     <= {entry[11:0], key_code};
                                entry_cnt <= entry_cnt + 3'd1;
                            end
                        end else if (key_code == 4'd14) begin
                            entry     <= '0;
                            entry_cnt <= '0;
                        end else if (key_code == 4'd15) begin
                            if (entry_cnt == 3'd4 && entry == CODE) begin
                                state <= DEFUSED;
                            end else begin
                                tries     <= tries + 3'd1;
                                entry     <= '0;
                                entry_cnt <= '0;
                                if (tries + 3'd1 == 3'(MAX_TRIES)) begin
                                    state <= DETONATED;
                                end else begin
`ifdef WRONG_PENALTY_EN
                                    penalty <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_keypad_decoder.sv
// Directed bench for bomb_keypad_decoder with a behavioural 4x4 keypad model.
module tb_bomb_keypad_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        armed = 1'b0;
    logic        expired = 1'b0;
    logic [3:0]  col, row, key_code;
    logic        key_valid, success, boom;
    logic [15:0] entry;
    logic [2:0]  entry_cnt, tries;

    int errors = 0;
    int checks = 0;

    logic       key_on = 1'b0;
    logic       dual = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;

    always #5 clk = ~clk;

    // Keypad: a pressed switch shorts its row to its column
    always_comb begin
        col = 4'hF;
        if (key_on && row[key_r] == 1'b0) col[key_c] = 1'b0;
        if (dual && row[0] == 1'b0) col = 4'b1100;
    end

`ifdef WRONG_PENALTY_EN
    logic penalty;
    int   pen_cnt = 0;
    always @(negedge clk) if (penalty) pen_cnt++;
`endif

    bomb_keypad_decoder #(
        .SCAN_DIV(4), .DEBOUNCE(2), .CODE(16'h2580), .MAX_TRIES(3)
    ) dut (
        .clk(clk), .rst(rst), .armed(armed), .expired(expired),
        .col(col), .row(row), .key_valid(key_valid), .key_code(key_code),
        .entry(entry), .entry_cnt(entry_cnt), .tries(tries),
        .success(success), .boom(boom)
`ifdef WRONG_PENALTY_EN
        , .penalty(penalty)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input logic [3:0] k);
        case (k)
            4'd1:  begin key_r = 2'd0; key_c = 2'd0; end
            4'd2:  begin key_r = 2'd0; key_c = 2'd1; end
            4'd3:  begin key_r = 2'd0; key_c = 2'd2; end
            4'd10: begin key_r = 2'd0; key_c = 2'd3; end
            4'd4:  begin key_r = 2'd1; key_c = 2'd0; end
            4'd5:  begin key_r = 2'd1; key_c = 2'd1; end
            4'd6:  begin key_r = 2'd1; key_c = 2'd2; end
            4'd11: begin key_r = 2'd1; key_c = 2'd3; end
            4'd7:  begin key_r = 2'd2; key_c = 2'd0; end
            4'd8:  begin key_r = 2'd2; key_c = 2'd1; end
            4'd9:  begin key_r = 2'd2; key_c = 2'd2; end
            4'd12: begin key_r = 2'd2; key_c = 2'd3; end
            4'd14: begin key_r = 2'd3; key_c = 2'd0; end
            4'd0:  begin key_r = 2'd3; key_c = 2'd1; end
            4'd15: begin key_r = 2'd3; key_c = 2'd2; end
            default: begin key_r = 2'd3; key_c = 2'd3; end
        endcase
        key_on = 1'b1;
    endtask

    // Returns at the falling edge where key_valid is seen, key still held
    task automatic press_hold(input logic [3:0] k);
        int n = 0;
        bit found = 0;
        set_key(k);
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (key_valid) found = 1;
        end
        check($sformatf("key_valid_seen_%0d", k), 16'(found), 16'd1);
        check($sformatf("key_code_%0d", k), 16'(key_code), 16'(k));
    endtask

    task automatic release_key();
        key_on = 1'b0;
        repeat (64) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        press_hold(k);
        release_key();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int n;

        repeat (3) @(negedge clk);
        check("rst_row", 16'(row), 16'hE);
        check("rst_key_valid", 16'(key_valid), 16'd0);
        check("rst_key_code", 16'(key_code), 16'd0);
        check("rst_entry", entry, 16'h0);
        check("rst_entry_cnt", 16'(entry_cnt), 16'd0);
        check("rst_tries", 16'(tries), 16'd0);
        check("rst_success", 16'(success), 16'd0);
        check("rst_boom", 16'(boom), 16'd0);
        rst = 1'b1;

        // Held '5' while idle: one pulse only, entry untouched
        set_key(4'd5);
        pulses = 0;
        repeat (64) begin @(negedge clk); if (key_valid) pulses++; end
        key_on = 1'b0;
        repeat (64) begin @(negedge clk); if (key_valid) pulses++; end
        check("hold5_pulses", 16'(pulses), 16'd1);
        check("hold5_code", 16'(key_code), 16'd5);
        check("idle_entry", entry, 16'h0);

        // Correct code
        armed = 1'b1;
        @(negedge clk);
        press(4'd2); press(4'd5); press(4'd8); press(4'd0);
        check("code_entry", entry, 16'h2580);
        check("code_entry_cnt", 16'(entry_cnt), 16'd4);
        press_hold(4'd15);
        check("success_not_yet", 16'(success), 16'd0);
        @(negedge clk);
        check("success_after_enter", 16'(success), 16'd1);
        check("no_boom_on_success", 16'(boom), 16'd0);
        release_key();

        // Three wrong submissions
        do_reset();
`ifdef WRONG_PENALTY_EN
        pen_cnt = 0;
`endif
        for (int t = 1; t <= 3; t++) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd15);
            if (t < 3) begin
                check($sformatf("wrong_tries_%0d", t), 16'(tries), 16'(t));
                check($sformatf("wrong_no_boom_%0d", t), 16'(boom), 16'd0);
                check($sformatf("wrong_entry_cleared_%0d", t), entry, 16'h0);
            end else begin
                check("wrong_boom", 16'(boom), 16'd1);
                check("wrong_tries_final", 16'(tries), 16'd3);
            end
        end
`ifdef WRONG_PENALTY_EN
        check("penalty_pulses", 16'(pen_cnt), 16'd2);
`endif

        // Clear, overflow digit, then submit
        do_reset();
        press(4'd2); press(4'd5);
        check("partial_entry", entry, 16'h0025);
        press(4'd14);
        check("clear_entry", entry, 16'h0);
        check("clear_cnt", 16'(entry_cnt), 16'd0);
        press(4'd2); press(4'd5); press(4'd8); press(4'd0);
        check("reentry", entry, 16'h2580);
        press(4'd9);
        check("fifth_digit_ignored", entry, 16'h2580);
        check("fifth_digit_cnt", 16'(entry_cnt), 16'd4);
        press(4'd15);
        check("success_after_clear", 16'(success), 16'd1);

        // Expiry coincident with the correct '#'
        do_reset();
        press(4'd2); press(4'd5); press(4'd8); press(4'd0);
        press_hold(4'd15);
        expired = 1'b1;
        @(negedge clk);
        expired = 1'b0;
        check("expiry_wins_boom", 16'(boom), 16'd1);
        check("expiry_wins_success", 16'(success), 16'd0);
        release_key();

        // Two columns low in a row is not a key
        do_reset();
        armed = 1'b0;
        press(4'd3);
        dual = 1'b1;
        pulses = 0;
        repeat (96) begin @(negedge clk); if (key_valid) pulses++; end
        dual = 1'b0;
        check("dual_col_pulses", 16'(pulses), 16'd0);
        check("dual_col_code_kept", 16'(key_code), 16'd3);

        // Reset while '7' is mid-debounce
        set_key(4'd7);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_row", 16'(row), 16'hE);
        check("midrst_key_valid", 16'(key_valid), 16'd0);
        check("midrst_key_code", 16'(key_code), 16'd0);
        check("midrst_entry", entry, 16'h0);
        check("midrst_success", 16'(success), 16'd0);
        check("midrst_boom", 16'(boom), 16'd0);
        rst = 1'b1;
        n = 0;
        while (n < 100 && !key_valid) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_latency", 16'(n), 16'd32);
        check("post_rst_code", 16'(key_code), 16'd7);
        release_key();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
